// File: rtl/rx_timer_pkg.sv
// Shared types and defaults for the UART receive bit-period timer.
package rx_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE,
        TMR_COUNT,
        TMR_DONE
    } timer_state_t;

    localparam int RX_DEF_CLKS_PER_BIT = 10;
    localparam int RX_DEF_DATA_BITS    = 8;

endpackage

// File: rtl/rx_timer_if.sv
// Handshake between the receiver control unit (master) and the bit timer (slave).
interface rx_timer_if;

    logic enable_timer;
    logic shift_strobe;
    logic packet_done;

    modport master (
        output enable_timer,
        input  shift_strobe,
        input  packet_done
    );

    modport slave (
        input  enable_timer,
        output shift_strobe,
        output packet_done
    );

endinterface

// File: rtl/rx_timer_flex_counter_sync.sv
// Up-counter that wraps from rollover_val back to 1; clear has priority over counting.
// rollover_flag is high while the count sits at rollover_val.
module flex_counter_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, hold, increment, or wrap to 1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = WIDTH'(1);
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// Bit-period timer for the UART receive path.
// Emits one shift_strobe per data/stop bit and a single packet_done per frame.
// Build option RX_TIMER_MIDBIT_EN: strobes move half a bit earlier (mid-bit sampling);
// packet_done timing is the same in both builds.
//
// state     | meaning
// TMR_IDLE  | no frame; counters held at 0
// TMR_COUNT | frame in progress, counting clocks and bits
// TMR_DONE  | all bits sampled; waiting for enable_timer to drop
module rx_timer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = RX_DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = RX_DEF_DATA_BITS
) (
    input  logic          clk,
    input  logic          n_rst,
    rx_timer_if.slave     tmr_if
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 2);

`ifdef RX_TIMER_MIDBIT_EN
    localparam int STROBE_CNT = CLKS_PER_BIT - CLKS_PER_BIT / 2;
`else
    localparam int STROBE_CNT = CLKS_PER_BIT;
`endif

    localparam logic [CW-1:0] CLK_ROLL   = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] STROBE_VAL = CW'(STROBE_CNT);
    localparam logic [BW-1:0] BIT_ROLL   = BW'(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("rx_timer: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("rx_timer: DATA_BITS must be >= 1");
    end

    timer_state_t  state_q, state_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;

    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_next;
    logic          clk_roll;
    logic          clk_clear;
    logic          clk_en;
    logic [BW-1:0] bit_cnt;
    logic          bit_roll;
    logic          bit_clear;
    logic          bit_en;

    flex_counter_sync #(.WIDTH(CW)) u_clk_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clk_clear),
        .count_enable  (clk_en),
        .rollover_val  (CLK_ROLL),
        .count_out     (clk_cnt),
        .rollover_flag (clk_roll)
    );

    flex_counter_sync #(.WIDTH(BW)) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bit_clear),
        .count_enable  (bit_en),
        .rollover_val  (BIT_ROLL),
        .count_out     (bit_cnt),
        .rollover_flag (bit_roll)
    );

    // Next-state, counter control and registered-output inputs.
    // A strobe is raised on the edge where clk_cnt moves onto STROBE_VAL, so the
    // pulse is visible for the cycle following that edge. bit_roll means every
    // bit has been strobed; the frame then completes on the next clk_cnt wrap.
    always_comb begin
        state_d   = state_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        clk_en    = 1'b0;
        bit_en    = 1'b0;
        clk_clear = !tmr_if.enable_timer;
        bit_clear = !tmr_if.enable_timer;
        clk_next  = clk_roll ? CW'(1) : clk_cnt + CW'(1);

        case (state_q)
            TMR_IDLE: begin
                if (tmr_if.enable_timer) begin
                    state_d  = TMR_COUNT;
                    clk_en   = 1'b1;
                    strobe_d = (clk_next == STROBE_VAL);
                    bit_en   = strobe_d;
                end
            end
            TMR_COUNT: begin
                if (!tmr_if.enable_timer) begin
                    state_d = TMR_IDLE;
                end else if (bit_roll && clk_roll) begin
                    state_d = TMR_DONE;
                    done_d  = 1'b1;
                end else begin
                    clk_en   = 1'b1;
                    strobe_d = !bit_roll && (clk_next == STROBE_VAL);
                    bit_en   = strobe_d;
                end
            end
            TMR_DONE: begin
                if (!tmr_if.enable_timer) begin
                    state_d = TMR_IDLE;
                end
            end
            default: begin
                state_d = TMR_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over enable_timer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= TMR_IDLE;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign tmr_if.shift_strobe = strobe_q;
    assign tmr_if.packet_done  = done_q;

endmodule

// File: tb/tb_rx_timer.sv
// Bench for rx_timer: a default-size instance and a minimum-size instance
// (CLKS_PER_BIT=2, DATA_BITS=1), each compared every cycle against an
// edge-number model of the frame timing.
module tb_rx_timer;

    localparam int C_A = 10;
    localparam int D_A = 8;
    localparam int C_B = 2;
    localparam int D_B = 1;

`ifdef RX_TIMER_MIDBIT_EN
    localparam bit MIDBIT = 1'b1;
`else
    localparam bit MIDBIT = 1'b0;
`endif

    logic clk;
    logic n_rst;

    int n_checks;
    int n_errors;
    int e_a;
    int e_b;

    rx_timer_if if_a ();
    rx_timer_if if_b ();

    rx_timer #(.CLKS_PER_BIT(C_A), .DATA_BITS(D_A)) u_dut_a (
        .clk    (clk),
        .n_rst  (n_rst),
        .tmr_if (if_a)
    );

    rx_timer #(.CLKS_PER_BIT(C_B), .DATA_BITS(D_B)) u_dut_b (
        .clk    (clk),
        .n_rst  (n_rst),
        .tmr_if (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // e = number of consecutive edges (counting the current one) at which the
    // timer was out of reset with enable_timer sampled high; 0 otherwise.
    function automatic int exp_strobe(input int e, input int c, input int d);
        int off;
        int m;
        off = MIDBIT ? c / 2 : 0;
        if (e < 1) return 0;
        if (((e + off) % c) != 0) return 0;
        m = (e + off) / c;
        return (m >= 1 && m <= d + 1) ? 1 : 0;
    endfunction

    function automatic int exp_done(input int e, input int c, input int d);
        return (e == (d + 1) * c + 1) ? 1 : 0;
    endfunction

    task automatic step(input logic rst_v, input logic en_a, input logic en_b);
        n_rst             = rst_v;
        if_a.enable_timer = en_a;
        if_b.enable_timer = en_b;
        @(posedge clk);
        e_a = (!rst_v || !en_a) ? 0 : e_a + 1;
        e_b = (!rst_v || !en_b) ? 0 : e_b + 1;
        #1;
        chk_eq("strobe_a", int'(if_a.shift_strobe), exp_strobe(e_a, C_A, D_A));
        chk_eq("done_a",   int'(if_a.packet_done),  exp_done(e_a, C_A, D_A));
        chk_eq("strobe_b", int'(if_b.shift_strobe), exp_strobe(e_b, C_B, D_B));
        chk_eq("done_b",   int'(if_b.packet_done),  exp_done(e_b, C_B, D_B));
        chk_eq("coincident_a", int'(if_a.shift_strobe && if_a.packet_done), 0);
        chk_eq("coincident_b", int'(if_b.shift_strobe && if_b.packet_done), 0);
    endtask

    task automatic run(input int n, input logic rst_v, input logic en_a, input logic en_b);
        for (int i = 0; i < n; i++) step(rst_v, en_a, en_b);
    endtask

    initial begin
        logic ra;
        logic rb;
        logic rr;
        n_checks = 0;
        n_errors = 0;
        e_a = 0;
        e_b = 0;
        n_rst = 1'b0;
        if_a.enable_timer = 1'b0;
        if_b.enable_timer = 1'b0;

        // reset state
        run(3, 1'b0, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);

        // full frame held 100 cycles
        run(100, 1'b1, 1'b1, 1'b1);
        run(2, 1'b1, 1'b0, 1'b0);

        // abort after edge 47, then re-enable
        run(47, 1'b1, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0, 1'b0);
        run(30, 1'b1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b0, 1'b0);

        // reset at edge 33 with enable still high
        run(32, 1'b1, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1, 1'b1);
        run(100, 1'b1, 1'b1, 1'b1);

        // linger 50 cycles in done, then drop and raise for a fresh frame
        run(50, 1'b1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b0, 1'b0);
        run(100, 1'b1, 1'b1, 1'b1);

        // randomized enable / reset activity
        ra = 1'b1;
        rb = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0)  rb = ~rb;
            rr = ($urandom_range(0, 299) != 0);
            step(rr, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
